// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC/fetch unit.
package pc_fetch_unit_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_MASK       = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_e;

  // Instructions are word aligned; the low two PC bits must match the mask.
  function automatic logic pc_is_aligned(input logic [31:0] pc);
    return pc[1:0] == ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of the next-PC, instruction-memory and decode handshake signals.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic [31:0]        NextPC;
  logic [31:0]        CurrentPC;
  logic [31:0]        ImemAddr;
  logic               ImemReq;
  logic               ImemAck;
  logic [INSTR_W-1:0] ImemData;
  logic [INSTR_W-1:0] Instruction;
  logic               InstrValid;
  logic               DecodeReady;
  logic [31:0]        InstrCount;
  logic               FetchErr;

  // Fetch unit side.
  modport master (
    input  NextPC, ImemAck, ImemData, DecodeReady,
    output CurrentPC, ImemAddr, ImemReq, Instruction, InstrValid,
           InstrCount, FetchErr
  );

  // Surrounding pipeline / memory side.
  modport slave (
    output NextPC, ImemAck, ImemData, DecodeReady,
    input  CurrentPC, ImemAddr, ImemReq, Instruction, InstrValid,
           InstrCount, FetchErr
  );

endinterface

// File: rtl/pc_fetch_unit_fetch_wait_timer.sv
// 8-bit wait-cycle counter for an outstanding fetch; flags the last
// permitted wait cycle so the FSM can time out on the following edge.
module pc_fetch_unit_fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  output logic       tc_o
);
  import pc_fetch_unit_pkg::*;

  localparam logic [7:0] TC_VAL = 8'(MAX_WAIT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear wins over load, load wins over count.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter register plus instruction fetch sequencer: requests the
// word at CurrentPC, holds it for decode, advances to NextPC on accept and
// traps timeouts / misaligned PCs into a sticky error state.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | just out of reset, about to issue the first request
//   ST_FETCH | ImemReq high, waiting for ImemAck (bounded by MAX_WAIT)
//   ST_ISSUE | Instruction valid, waiting for DecodeReady
//   ST_ERROR | timeout or misaligned PC; parked until Reset
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MAX_WAIT = 15
) (
  input  logic            Clk,
  input  logic            Reset,
  pc_fetch_unit_if.master bus
);

  fetch_state_e       state_q;
  logic [31:0]        pc_q;
  logic               imem_req_q;
  logic [INSTR_W-1:0] instr_q;
  logic               instr_valid_q;
  logic [31:0]        instr_count_q;
  logic               fetch_err_q;

  logic accept;
  logic wait_clr;
  logic wait_en;
  logic wait_tc;

  assign accept   = (state_q == ST_ISSUE) && bus.DecodeReady;
  // Timer restarts whenever a new fetch request is about to be raised.
  assign wait_clr = (state_q == ST_IDLE) || accept;
  assign wait_en  = (state_q == ST_FETCH) && !bus.ImemAck && !wait_tc;

  pc_fetch_unit_fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .clr_i      (wait_clr),
    .load_i     (1'b0),
    .load_val_i (8'd0),
    .en_i       (wait_en),
    .tc_o       (wait_tc)
  );

  // Fetch FSM with the PC, instruction and counter registers it owns.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_count_q <= 32'd0;
      fetch_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!pc_is_aligned(RESET_PC)) begin
            fetch_err_q <= 1'b1;
            state_q     <= ST_ERROR;
          end else begin
            imem_req_q <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (bus.ImemAck) begin
            instr_q       <= bus.ImemData;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= ST_ISSUE;
          end else if (wait_tc) begin
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= ST_ERROR;
          end
        end

        ST_ISSUE: begin
          if (bus.DecodeReady) begin
            // The faulting PC is still loaded so it is visible for debug.
            pc_q          <= bus.NextPC;
            instr_valid_q <= 1'b0;
            instr_count_q <= instr_count_q + 32'd1;
            if (!pc_is_aligned(bus.NextPC)) begin
              fetch_err_q <= 1'b1;
              state_q     <= ST_ERROR;
            end else begin
              imem_req_q <= 1'b1;
              state_q    <= ST_FETCH;
            end
          end
        end

        ST_ERROR: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          fetch_err_q   <= 1'b1;
        end

        default: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          fetch_err_q   <= 1'b1;
          state_q       <= ST_ERROR;
        end
      endcase
    end
  end

  assign bus.CurrentPC   = pc_q;
  assign bus.ImemAddr    = pc_q;
  assign bus.ImemReq     = imem_req_q;
  assign bus.Instruction = instr_q;
  assign bus.InstrValid  = instr_valid_q;
  assign bus.InstrCount  = instr_count_q;
  assign bus.FetchErr    = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table, directed corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam int          MAX_WAIT = 15;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic Clk;
  logic Reset;
  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endfunction

  // ---------------- behavioural model ----------------
  // Phases: 0 starting, 1 waiting on memory, 2 holding for decode, 3 dead.
  int          m_phase;
  int          m_waited;
  logic [31:0] m_pc, m_instr, m_cnt;
  logic        m_req, m_valid, m_err;

  task automatic model_step();
    if (Reset) begin
      m_phase = 0; m_waited = 0; m_pc = RST_PC; m_instr = 0; m_cnt = 0;
      m_req = 0; m_valid = 0; m_err = 0;
    end else if (m_phase == 0) begin
      if (RST_PC % 4 != 0) begin m_phase = 3; m_err = 1; end
      else begin m_phase = 1; m_req = 1; m_waited = 0; end
    end else if (m_phase == 1) begin
      if (bus.ImemAck) begin
        m_instr = bus.ImemData; m_valid = 1; m_req = 0; m_phase = 2;
      end else begin
        m_waited++;
        if (m_waited >= MAX_WAIT) begin m_phase = 3; m_err = 1; m_req = 0; end
      end
    end else if (m_phase == 2) begin
      if (bus.DecodeReady) begin
        m_pc = bus.NextPC; m_valid = 0; m_cnt = m_cnt + 1;
        if (bus.NextPC % 4 != 0) begin m_phase = 3; m_err = 1; end
        else begin m_phase = 1; m_req = 1; m_waited = 0; end
      end
    end
  endtask

  // Advance one clock with the model in lockstep; outputs settle by #1.
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".pc"},    bus.CurrentPC,   m_pc);
    chk({tag, ".addr"},  bus.ImemAddr,    m_pc);
    chk({tag, ".req"},   32'(bus.ImemReq),    32'(m_req));
    chk({tag, ".instr"}, bus.Instruction, m_instr);
    chk({tag, ".valid"}, 32'(bus.InstrValid), 32'(m_valid));
    chk({tag, ".cnt"},   bus.InstrCount,  m_cnt);
    chk({tag, ".err"},   32'(bus.FetchErr),   32'(m_err));
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, ".pc"},    bus.CurrentPC,   RST_PC);
    chk({tag, ".req"},   32'(bus.ImemReq),    32'd0);
    chk({tag, ".instr"}, bus.Instruction, 32'd0);
    chk({tag, ".valid"}, 32'(bus.InstrValid), 32'd0);
    chk({tag, ".cnt"},   bus.InstrCount,  32'd0);
    chk({tag, ".err"},   32'(bus.FetchErr),   32'd0);
  endtask

  task automatic drive(logic r, logic a, logic [31:0] d, logic rdy, logic [31:0] npc);
    Reset = r; bus.ImemAck = a; bus.ImemData = d; bus.DecodeReady = rdy; bus.NextPC = npc;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic [31:0] npc;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  localparam logic [31:0] DW = 32'h2008_0005;
  localparam logic [31:0] BW = 32'hDEAD_BEEF;
  localparam logic [31:0] XW = 32'h1234_5678;

  vec_t vt[15];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_req;
    logic [31:0] pc_hold, instr_hold;

    //        rst ack data rdy npc        -> pc     req valid instr cnt
    vt[0]  = '{1, 1, DW, 1, 32'h04,      32'h00, 0, 0, 32'h0, 0};
    vt[1]  = '{0, 1, DW, 1, 32'h04,      32'h00, 1, 0, 32'h0, 0};
    vt[2]  = '{0, 1, DW, 1, 32'h04,      32'h00, 0, 1, DW,    0};
    vt[3]  = '{0, 1, DW, 1, 32'h04,      32'h04, 1, 0, DW,    1};
    vt[4]  = '{0, 1, DW, 1, 32'h08,      32'h04, 0, 1, DW,    1};
    vt[5]  = '{0, 1, DW, 1, 32'h08,      32'h08, 1, 0, DW,    2};
    vt[6]  = '{0, 1, DW, 1, 32'h0C,      32'h08, 0, 1, DW,    2};
    vt[7]  = '{0, 1, DW, 1, 32'h0C,      32'h0C, 1, 0, DW,    3};
    vt[8]  = '{0, 0, BW, 1, 32'h10,      32'h0C, 1, 0, DW,    3};
    vt[9]  = '{0, 0, BW, 1, 32'h10,      32'h0C, 1, 0, DW,    3};
    vt[10] = '{0, 0, BW, 1, 32'h10,      32'h0C, 1, 0, DW,    3};
    vt[11] = '{0, 1, BW, 0, 32'h10,      32'h0C, 0, 1, BW,    3};
    vt[12] = '{0, 1, XW, 0, 32'h100,     32'h0C, 0, 1, BW,    3};
    vt[13] = '{0, 0, XW, 0, 32'h200,     32'h0C, 0, 1, BW,    3};
    vt[14] = '{0, 0, XW, 1, 32'h40,      32'h40, 1, 0, BW,    4};

    drive(1, 0, 0, 0, 0);
    tick();
    tick();
    check_reset_vals("reset");

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].rst, vt[i].ack, vt[i].data, vt[i].rdy, vt[i].npc);
      tick();
      chk($sformatf("vec%0d.pc", i),    bus.CurrentPC,       vt[i].e_pc);
      chk($sformatf("vec%0d.req", i),   32'(bus.ImemReq),    32'(vt[i].e_req));
      chk($sformatf("vec%0d.valid", i), 32'(bus.InstrValid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d.instr", i), bus.Instruction,     vt[i].e_instr);
      chk($sformatf("vec%0d.cnt", i),   bus.InstrCount,      vt[i].e_cnt);
      chk($sformatf("vec%0d.err", i),   32'(bus.FetchErr),   32'd0);
    end

    // Decode backpressure with NextPC wandering, then accept at 0x40+.
    drive(0, 1, 32'hCAFE_0001, 0, 32'h44);
    tick();
    pc_hold = bus.CurrentPC; instr_hold = bus.Instruction;
    chk("bp.pc_before", pc_hold, 32'h40);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, $urandom, 0, {$urandom_range(0, 1023), 2'b00});
      tick();
      chk("bp.pc",    bus.CurrentPC,       pc_hold);
      chk("bp.instr", bus.Instruction,     32'hCAFE_0001);
      chk("bp.valid", 32'(bus.InstrValid), 32'd1);
    end
    drive(0, 0, 0, 1, 32'h0040_0100);
    tick();
    chk("jump.addr", bus.ImemAddr,       32'h0040_0100);
    chk("jump.req",  32'(bus.ImemReq),   32'd1);
    check_model("jump");

    // Misaligned target traps and stays trapped.
    drive(0, 1, 32'h0BAD_0000, 1, 32'h0);
    tick();
    drive(0, 1, 32'h0, 1, 32'h0000_0042);
    tick();
    chk("mis.err", 32'(bus.FetchErr), 32'd1);
    chk("mis.req", 32'(bus.ImemReq),  32'd0);
    chk("mis.pc",  bus.CurrentPC,     32'h0000_0042);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, $urandom, 1, 32'h100);
      tick();
      chk("mis.hold_err",   32'(bus.FetchErr),   32'd1);
      chk("mis.hold_req",   32'(bus.ImemReq),    32'd0);
      chk("mis.hold_valid", 32'(bus.InstrValid), 32'd0);
    end

    // Timeout: count request cycles until the error shows.
    drive(1, 0, 0, 0, 0);
    tick();
    check_reset_vals("rst_err");
    drive(0, 0, 0, 0, 0);
    tick();
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.FetchErr) break;
      if (bus.ImemReq) n_req++;
      tick();
    end
    chk("timeout.err",      32'(bus.FetchErr), 32'd1);
    chk("timeout.req_cyc",  32'(n_req),        32'(MAX_WAIT));
    chk("timeout.req_low",  32'(bus.ImemReq),  32'd0);
    check_model("timeout");

    // Reset mid-FETCH.
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick(); tick();
    chk("midfetch.req", 32'(bus.ImemReq), 32'd1);
    drive(1, 1, 32'h5555_AAAA, 0, 0); tick();
    check_reset_vals("rst_midfetch");

    // Reset mid-ISSUE.
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h7777_0000, 0, 0); tick();
    chk("midissue.valid", 32'(bus.InstrValid), 32'd1);
    drive(1, 0, 0, 1, 32'h8); tick();
    check_reset_vals("rst_midissue");

    // Counter wrap: preload the count while decode is stalled.
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h1111_2222, 0, 32'h4); tick();
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    m_cnt = 32'hFFFF_FFFF;
    chk("wrap.pre", bus.InstrCount, 32'hFFFF_FFFF);
    drive(0, 0, 0, 1, 32'h4); tick();
    chk("wrap.post", bus.InstrCount, 32'h0);
    chk("wrap.pc",   bus.CurrentPC,  32'h4);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic r, a, rdy;
      logic [31:0] npc;
      r   = (m_phase == 3) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 150) == 0);
      a   = ($urandom_range(0, 99) < 45);
      rdy = ($urandom_range(0, 99) < 55);
      npc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 40) == 0) npc[1:0] = 2'($urandom_range(1, 3));
      drive(r, a, $urandom, rdy, npc);
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential counterpart to the next-PC logic: holds the program counter register, drives it out as CurrentPC, and loads NextPC when the current instruction is consumed.
- Fetches each instruction from instruction memory over a req/ack handshake.
- Presents the fetched word to decode over a valid/ready handshake.
- Flags fetch timeouts and misaligned PCs with a sticky error.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, max cycles ImemReq may stay high without ImemAck before timeout (1..255)

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
NextPC  in  32  next PC from next-PC logic (function of CurrentPC/Branch/Jump)
CurrentPC  out  32  registered program counter
ImemAddr  out  32  instruction memory address, combinationally equal to CurrentPC
ImemReq  out  1  registered fetch request
ImemAck  in  1  memory response; ImemData valid in the same cycle
ImemData  in  32  instruction word
Instruction  out  32  registered instruction held for decode
InstrValid  out  1  Instruction is valid
DecodeReady  in  1  decode accepts Instruction this cycle
InstrCount  out  32  retired-fetch counter
FetchErr  out  1  sticky error (timeout or misaligned PC)

Behaviour:
- Reset is synchronous, active-high, and overrides everything including mid-handshake. Reset values:
  - CurrentPC=RESET_PC, ImemReq=0, Instruction=0, InstrValid=0
  - InstrCount=0, FetchErr=0, wait counter=0, state=IDLE
- FSM states:
  - IDLE: next cycle set ImemReq=1, clear wait counter, go to FETCH. Exception: if RESET_PC[1:0]!=0, go to ERROR.
  - FETCH: ImemReq=1.
    - If ImemAck=1: Instruction<=ImemData, InstrValid<=1, ImemReq<=0, go to ISSUE.
    - Else if wait counter==MAX_WAIT-1: go to ERROR.
    - Else: wait counter+1.
    - Zero-wait memory (ack in the first FETCH cycle) is legal. InstrValid rises the cycle after ack.
  - ISSUE: InstrValid=1; Instruction and CurrentPC are stable.
    - On DecodeReady=1: CurrentPC<=NextPC, InstrValid<=0, InstrCount<=InstrCount+1.
    - Then, if NextPC[1:0]!=0: go to ERROR, with CurrentPC still loaded with NextPC.
    - Else: ImemReq<=1, clear wait counter, go to FETCH.
    - DecodeReady=0: hold everything indefinitely.
  - ERROR: ImemReq=0, InstrValid=0, FetchErr=1. Stays in ERROR until Reset.
- Handshake rules:
  - ImemAck is ignored outside FETCH.
  - ImemData is sampled only on ack.
  - DecodeReady is ignored outside ISSUE.
  - No back-to-back issue: the minimum period per instruction is 2 cycles (FETCH with ack, ISSUE with ready).
- NextPC is sampled only on the ISSUE accept edge; the upstream next-PC logic may settle freely at other times.
- Arithmetic:
  - InstrCount is 32-bit unsigned and wraps 32'hFFFF_FFFF -> 0.
  - Wait counter is 8-bit.
  - No PC arithmetic is done here; PC+4, branch and jump targets come in through NextPC.
- Timeout: exactly MAX_WAIT consecutive FETCH cycles without ack -> FetchErr=1 on the following cycle.

Decomposition:
- Shared package:
  - state enum (IDLE, FETCH, ISSUE, ERROR)
  - RESET_PC default
  - INSTR_W=32
  - the word-alignment mask 2'b00
- One natural sub-module, fetch_wait_timer: a loadable 8-bit counter with clear, enable and a terminal flag at MAX_WAIT-1.
- Everything else (FSM, PC register, instruction register, InstrCount) stays in pc_fetch_unit.

Test Plan:
- Reset then zero-wait memory: ImemAck tied 1, ImemData=32'h2008_0005, DecodeReady=1, NextPC=CurrentPC+4.
  -> InstrValid on cycle 3 after reset release; CurrentPC 0,4,8 every 2 cycles; InstrCount increments per accept.
- Wait states: ack 3 cycles after ImemReq.
  -> ImemReq high exactly 4 cycles; Instruction captured on the ack cycle; no FetchErr.
- Decode backpressure: DecodeReady=0 for 5 cycles in ISSUE with NextPC changing.
  -> CurrentPC, Instruction and InstrValid stable; CurrentPC loads the NextPC value present on the accept cycle (e.g. 32'h0000_0040).
- Jump/branch target: NextPC=32'h0040_0100 on accept.
  -> ImemAddr=32'h0040_0100 in the next FETCH.
  Misaligned case: NextPC=32'h0000_0042 on accept.
  -> FetchErr=1, ImemReq=0, held until Reset.
- Timeout: ImemAck=0 with MAX_WAIT=15.
  -> FetchErr asserts after exactly 15 FETCH cycles.
  Reset mid-FETCH and mid-ISSUE -> all outputs return to reset values on the next edge.
- Counter wrap: preload through 2^32 accepts (or force InstrCount=32'hFFFF_FFFF).
  -> InstrCount=0 after the next accept.
